anpc_pwm_level_gen: RTL and testbench

Carrier-based modulator stage that sits directly upstream of the 3L-ANPC commutation FSM. It produces the FSM's 2-bit `v_lev` command: 0 = zero, 1 = P, 2 = N. Generation uses a symmetric triangular carrier compared against a signed, shadow-buffered reference. The block also enforces a minimum level dwell time and forbids direct P<->N steps, so the downstream FSM always finishes a commutation sequence before the next request arrives.

---
 rtl/anpc_pwm_level_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_anpc_pwm_level_gen.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anpc_pwm_level_gen.sv
// ---------------------------------------------------------------------------
// anpc_pwm_level_gen
//
// Carrier-based level generator feeding the 3L-ANPC commutation FSM.
// A symmetric triangular carrier (0 .. eff_period .. 1) is compared with
// the magnitude of a signed, shadow-buffered reference. The result is a
// level command: 0 = zero, 1 = P, 2 = N. Every level is held for at least
// t_min ce cycles. A P<->N request always passes through zero first, so the
// downstream FSM finishes one commutation before the next one arrives.
//
// Optional feature (macro ANPC_PWM_DOUBLE_UPDATE_EN):
//   defined   - the carrier peak also loads the active reference (but not
//               the active period) and pulses sync, giving two reference
//               updates per carrier cycle.
//   undefined - shadow load and sync happen only at the carrier valley.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ce         clock enable; state advances only when ce=1
//   enable     run; 0 forces level zero and parks the carrier at the valley
//   period     carrier peak count (half period in ce cycles)
//   ref_in     signed reference, in carrier counts
//   ref_valid  strobe; captures ref_in/period into the pending registers
//   t_min      minimum ce cycles between v_lev changes
//   v_lev      level command (0 zero, 1 P, 2 N)
//   sync       one-cycle pulse on each shadow-load event
//   carrier    current carrier value
//   dir        carrier direction (1 = counting up)
// ---------------------------------------------------------------------------
module anpc_pwm_level_gen #(
    parameter int CNT_W = 16,
    parameter int REF_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        period,
    input  logic signed [REF_W-1:0] ref_in,
    input  logic                    ref_valid,
    input  logic [7:0]              t_min,
    output logic [1:0]              v_lev,
    output logic                    sync,
    output logic [CNT_W-1:0]        carrier,
    output logic                    dir
);

    typedef enum logic [1:0] {
        LEV_ZERO = 2'd0,
        LEV_P    = 2'd1,
        LEV_N    = 2'd2
    } level_e;

    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [REF_W-1:0] REF_ONE    = REF_W'(1);
    localparam logic [REF_W-1:0] REF_MOSTNEG = {1'b1, {(REF_W-1){1'b0}}};

    logic [CNT_W-1:0]        carrier_q, carrier_d;
    logic                    dir_q, dir_d;
    level_e                  v_lev_q, v_lev_d;
    logic [7:0]              dwell_q, dwell_d;
    logic                    sync_q, sync_d;
    logic signed [REF_W-1:0] refPend_q, refAct_q;
    logic [CNT_W-1:0]        perPend_q, perAct_q;

    logic [CNT_W-1:0] effPeriod;
    logic             valleyEvt;
    logic             peakEvt;
    logic [REF_W-1:0] refBits;
    logic [REF_W-1:0] refNegated;
    logic             refNeg;
    logic [REF_W-2:0] magRaw;
    logic [CNT_W-1:0] magSat;
    level_e           cand;

    // Periods of 0 or 1 would collapse the triangle, so clamp to 2.
    assign effPeriod = (perAct_q < MIN_PERIOD) ? MIN_PERIOD : perAct_q;

    assign valleyEvt = ce & enable & dir_q & (carrier_q == '0);
    assign peakEvt   = ce & enable & dir_q & (carrier_q == effPeriod);

`ifdef ANPC_PWM_DOUBLE_UPDATE_EN
    assign sync_d = valleyEvt | peakEvt;
`else
    assign sync_d = valleyEvt;
`endif

    // Pending registers capture on every strobe, independent of ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refPend_q <= '0;
            perPend_q <= MIN_PERIOD;
        end else if (ref_valid) begin
            refPend_q <= ref_in;
            perPend_q <= period;
        end
    end

    // Active registers read the old pending values, so a strobe landing on
    // a load event only reaches the active copy at the following event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refAct_q <= '0;
            perAct_q <= MIN_PERIOD;
        end else if (valleyEvt) begin
            refAct_q <= refPend_q;
            perAct_q <= perPend_q;
`ifdef ANPC_PWM_DOUBLE_UPDATE_EN
        end else if (peakEvt) begin
            refAct_q <= refPend_q;
`endif
        end
    end

    // Triangle: up to eff_period, then down to 1, then back to 0 going up.
    always_comb begin
        carrier_d = carrier_q;
        dir_d     = dir_q;
        if (!enable) begin
            carrier_d = '0;
            dir_d     = 1'b1;
        end else if (dir_q) begin
            if (carrier_q >= effPeriod) begin
                carrier_d = carrier_q - CNT_ONE;
                dir_d     = 1'b0;
            end else begin
                carrier_d = carrier_q + CNT_ONE;
            end
        end else begin
            if (carrier_q <= CNT_ONE) begin
                carrier_d = '0;
                dir_d     = 1'b1;
            end else begin
                carrier_d = carrier_q - CNT_ONE;
            end
        end
    end

    // Absolute value; the most-negative code has no positive twin and
    // saturates to the largest positive magnitude.
    assign refBits    = refAct_q;
    assign refNeg     = refBits[REF_W-1];
    assign refNegated = ~refBits + REF_ONE;

    always_comb begin
        magRaw = refBits[REF_W-2:0];
        if (refNeg) begin
            if (refBits == REF_MOSTNEG) begin
                magRaw = '1;
            end else begin
                magRaw = refNegated[REF_W-2:0];
            end
        end
    end

    generate
        if (REF_W - 1 > CNT_W) begin : gen_mag_sat
            always_comb begin
                magSat = magRaw[CNT_W-1:0];
                if (|magRaw[REF_W-2:CNT_W]) begin
                    magSat = '1;
                end
            end
        end else begin : gen_mag_ext
            assign magSat = CNT_W'(magRaw);
        end
    endgenerate

    assign cand = (magSat > carrier_q) ? (refNeg ? LEV_N : LEV_P) : LEV_ZERO;

    // Level update with dwell guard; a blocked request is simply retried
    // next cycle, nothing is queued. Disable bypasses the dwell guard.
    always_comb begin
        v_lev_d = v_lev_q;
        dwell_d = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
        if (!enable) begin
            v_lev_d = LEV_ZERO;
            if (v_lev_q != LEV_ZERO) begin
                dwell_d = '0;
            end
        end else if ((cand != v_lev_q) && (dwell_q >= t_min)) begin
            dwell_d = '0;
            if (((v_lev_q == LEV_P) && (cand == LEV_N)) ||
                ((v_lev_q == LEV_N) && (cand == LEV_P))) begin
                v_lev_d = LEV_ZERO;
            end else begin
                v_lev_d = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carrier_q <= '0;
            dir_q     <= 1'b1;
            v_lev_q   <= LEV_ZERO;
            dwell_q   <= '0;
        end else if (ce) begin
            carrier_q <= carrier_d;
            dir_q     <= dir_d;
            v_lev_q   <= v_lev_d;
            dwell_q   <= dwell_d;
        end
    end

    // sync is recomputed every clock so it never outlives its ce cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign v_lev   = v_lev_q;
    assign sync    = sync_q;
    assign carrier = carrier_q;
    assign dir     = dir_q;

endmodule

// File: tb/tb_anpc_pwm_level_gen.sv
// ---------------------------------------------------------------------------
// tb_anpc_pwm_level_gen
//
// Directed bench for anpc_pwm_level_gen. A short table of per-cycle vectors
// (period 4) walks the carrier, shadow load, ce hold and the P->0->N rule;
// hand-written sequences then cover the long-period waveforms, dwell time,
// ce stretching, enable drop, asynchronous reset and the period clamp.
// Honours ANPC_PWM_DOUBLE_UPDATE_EN to expect the extra peak sync.
// ---------------------------------------------------------------------------
module tb_anpc_pwm_level_gen;

`ifdef ANPC_PWM_DOUBLE_UPDATE_EN
    localparam logic DU             = 1'b1;
    localparam int   SYNC_PER_CYCLE = 2;
`else
    localparam logic DU             = 1'b0;
    localparam int   SYNC_PER_CYCLE = 1;
`endif

    logic               clk;
    logic               rst_n;
    logic               ce;
    logic               enable;
    logic [15:0]        period;
    logic signed [15:0] ref_in;
    logic               ref_valid;
    logic [7:0]         t_min;
    logic [1:0]         v_lev;
    logic               sync;
    logic [15:0]        carrier;
    logic               dir;

    int checks;
    int errors;

    typedef struct {
        logic               ce;
        logic               en;
        logic               rv;
        logic signed [15:0] refIn;
        logic [1:0]         expV;
        logic               expS;
        logic [15:0]        expC;
        logic               expD;
    } vec_t;

    vec_t vecs[23];

    anpc_pwm_level_gen #(.CNT_W(16), .REF_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .enable    (enable),
        .period    (period),
        .ref_in    (ref_in),
        .ref_valid (ref_valid),
        .t_min     (t_min),
        .v_lev     (v_lev),
        .sync      (sync),
        .carrier   (carrier),
        .dir       (dir)
    );

    // 10 time-unit clock; outputs are sampled 1 unit after the rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step with whatever inputs are currently driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Generic scalar comparison used by the hand-written sequences.
    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one table vector for a single clock.
    task automatic applyStimulus(input vec_t v);
        ce        = v.ce;
        enable    = v.en;
        ref_valid = v.rv;
        ref_in    = v.refIn;
        tick();
        ref_valid = 1'b0;
    endtask

    // Compares all four outputs against one table vector.
    task automatic checkOutput(input int idx, input vec_t v);
        checks++;
        if (v_lev !== v.expV || sync !== v.expS || carrier !== v.expC || dir !== v.expD) begin
            errors++;
            $display("[TB] FAIL vec[%0d]: got v_lev=%0d sync=%0d carrier=%0d dir=%0d, expected v_lev=%0d sync=%0d carrier=%0d dir=%0d",
                     idx, v_lev, sync, carrier, dir, v.expV, v.expS, v.expC, v.expD);
        end
    endtask

    // Holds reset for two clocks with all inputs idle, then releases it.
    task automatic doReset();
        rst_n     = 1'b0;
        ce        = 1'b0;
        enable    = 1'b0;
        ref_valid = 1'b0;
        ref_in    = '0;
        period    = '0;
        t_min     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Strobes a new period/reference into the pending registers while
    // the modulator is still disabled.
    task automatic loadRef(input int per, input int refVal, input int tm);
        period    = 16'(per);
        ref_in    = 16'(refVal);
        t_min     = 8'(tm);
        ce        = 1'b1;
        enable    = 1'b0;
        ref_valid = 1'b1;
        tick();
        ref_valid = 1'b0;
    endtask

    // Main sequence: table vectors first, then the multi-cycle scenarios.
    initial begin
        int ones, twos, syncs, maxC, notP, zl, holdErr, prevC;
        bit found;
        int expC7[8];
        logic expS7[8];

        checks = 0;
        errors = 0;

        // Reset values, checked while reset is still asserted.
        rst_n = 1'b0;
        ce = 1'b0; enable = 1'b0; ref_valid = 1'b0;
        ref_in = '0; period = '0; t_min = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset v_lev", int'(v_lev), 0);
        checkVal("reset sync", int'(sync), 0);
        checkVal("reset carrier", int'(carrier), 0);
        checkVal("reset dir", int'(dir), 1);
        rst_n = 1'b1;

        // Period 4, ref +2, t_min 0. Row k is the output after clock k.
        vecs[0]  = '{1'b1, 1'b0, 1'b1,  16'sd2, 2'd0, 1'b0, 16'd0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b1, 16'd1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd1, 1'b0, 16'd2, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd3, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd4, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, DU,   16'd3, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd2, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd1, 1'b0, 16'd0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd1, 1'b1, 16'd1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd1, 1'b0, 16'd2, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd3, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd4, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, DU,   16'd3, 1'b0};
        // ce low: everything holds, strobe of -3 still lands in pending.
        vecs[14] = '{1'b0, 1'b1, 1'b1, -16'sd3, 2'd0, 1'b0, 16'd3, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd2, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd1, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd1, 1'b0, 16'd0, 1'b1};
        // Valley loads -3; the coincident +1 strobe stays pending.
        vecs[18] = '{1'b1, 1'b1, 1'b1,  16'sd1, 2'd1, 1'b1, 16'd1, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd2, 1'b1};
        vecs[20] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd2, 1'b0, 16'd3, 1'b1};
        vecs[21] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, 1'b0, 16'd4, 1'b1};
        vecs[22] = '{1'b1, 1'b1, 1'b0,  16'sd2, 2'd0, DU,   16'd3, 1'b0};

        period = 16'd4;
        t_min  = 8'd0;
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Period 100, ref +50: P while 50 > carrier, i.e. carrier 0..49 up
        // and 49..1 down = 99 of every 200 cycles.
        doReset();
        loadRef(100, 50, 0);
        enable = 1'b1;
        repeat (10) tick();
        ones = 0; twos = 0; syncs = 0; maxC = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (v_lev == 2'd1) ones++;
            if (v_lev == 2'd2) twos++;
            if (sync) syncs++;
            if (int'(carrier) > maxC) maxC = int'(carrier);
        end
        checkVal("pos50 P cycles", ones, 99);
        checkVal("pos50 N cycles", twos, 0);
        checkVal("pos50 sync count", syncs, SYNC_PER_CYCLE);
        checkVal("pos50 carrier peak", maxC, 100);

        // Negative reference mirrors onto N; most-negative code saturates.
        doReset();
        loadRef(100, -50, 0);
        enable = 1'b1;
        repeat (10) tick();
        ones = 0; twos = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (v_lev == 2'd1) ones++;
            if (v_lev == 2'd2) twos++;
        end
        checkVal("neg50 N cycles", twos, 99);
        checkVal("neg50 P cycles", ones, 0);
        ref_in = 16'sh8000;
        ref_valid = 1'b1;
        tick();
        ref_valid = 1'b0;
        repeat (210) tick();
        twos = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (v_lev == 2'd2) twos++;
        end
        checkVal("mostneg stuck N", twos, 200);

        // Steady P, then -120 with t_min 10: 1 -> 0 for 11 cycles -> 2.
        doReset();
        loadRef(100, 120, 10);
        enable = 1'b1;
        repeat (250) tick();
        checkVal("tmin10 steady P", int'(v_lev), 1);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (carrier == 16'd30 && dir) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkVal("tmin10 reach carrier 30", int'(found), 1);
        ref_in = -16'sd120;
        ref_valid = 1'b1;
        tick();
        ref_valid = 1'b0;
        found = 1'b0;
        notP = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (v_lev != 2'd1) notP++;
            if (sync) begin
                found = 1'b1;
                break;
            end
        end
        checkVal("tmin10 load event seen", int'(found), 1);
        checkVal("tmin10 P held until load", notP, 0);
        tick();
        checkVal("tmin10 first step is zero", int'(v_lev), 0);
        zl = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (v_lev != 2'd0) break;
            zl++;
        end
        checkVal("tmin10 zero dwell length", zl, 11);
        checkVal("tmin10 final level N", int'(v_lev), 2);

        // ref +10 gives a 19-cycle P request; t_min 30 stretches it to 31.
        doReset();
        loadRef(100, 10, 30);
        enable = 1'b1;
        repeat (300) tick();
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (v_lev == 2'd0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkVal("tmin30 find zero", int'(found), 1);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (v_lev == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        checkVal("tmin30 find P", int'(found), 1);
        ones = 1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (v_lev != 2'd1) break;
            ones++;
        end
        checkVal("tmin30 P run length", ones, 31);
        zl = 1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (v_lev != 2'd0) break;
            zl++;
        end
        checkVal("tmin30 zero run length", zl, 169);

        // ce alternating 1,0: every output value lasts two clocks.
        doReset();
        loadRef(100, 50, 0);
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ce = (i % 2 == 0);
            tick();
        end
        ones = 0; syncs = 0; holdErr = 0;
        for (int i = 0; i < 400; i++) begin
            ce = (i % 2 == 0);
            prevC = int'(carrier);
            tick();
            if (!ce && int'(carrier) != prevC) holdErr++;
            if (v_lev == 2'd1) ones++;
            if (sync) syncs++;
        end
        checkVal("ce half P clocks", ones, 198);
        checkVal("ce half sync count", syncs, SYNC_PER_CYCLE);
        checkVal("ce half carrier hold", holdErr, 0);
        ce = 1'b1;

        // Enable drop bypasses a 50-cycle dwell, then async reset mid-carrier.
        doReset();
        loadRef(100, 50, 50);
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (v_lev == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        checkVal("endrop reach P", int'(found), 1);
        repeat (3) tick();
        checkVal("endrop P before drop", int'(v_lev), 1);
        enable = 1'b0;
        tick();
        checkVal("endrop v_lev", int'(v_lev), 0);
        checkVal("endrop carrier", int'(carrier), 0);
        checkVal("endrop dir", int'(dir), 1);
        checkVal("endrop sync", int'(sync), 0);
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (carrier == 16'd50 && !dir) begin
                found = 1'b1;
                break;
            end
        end
        checkVal("areset reach carrier 50 down", int'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("areset v_lev", int'(v_lev), 0);
        checkVal("areset carrier", int'(carrier), 0);
        checkVal("areset dir", int'(dir), 1);
        checkVal("areset sync", int'(sync), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Period 0 behaves as period 2: carrier 1,2,1,0 repeating.
        doReset();
        loadRef(0, 0, 0);
        enable = 1'b1;
        expC7 = '{1, 2, 1, 0, 1, 2, 1, 0};
        expS7 = '{1'b1, 1'b0, DU, 1'b0, 1'b1, 1'b0, DU, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tick();
            checkVal($sformatf("clamp carrier[%0d]", i), int'(carrier), expC7[i]);
            checkVal($sformatf("clamp sync[%0d]", i), int'(sync), int'(expS7[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
